// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB plus 2-bit PHT next-PC predictor with bimodal/gshare indexing,
// a one-entry-per-cycle table flush and saturating lookup/mispredict statistics.
module branch_predictor #(
    parameter int WORD_SIZE = 16,
    parameter int ENTRIES   = 16,
    parameter int HIST_BITS = 4,
    parameter int MODE      = 0
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 if_valid,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic                 pred_hit,
    output logic                 pred_taken,
    output logic [WORD_SIZE-1:0] pred_target,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic                 upd_is_cond,
    input  logic                 upd_taken,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_mispredict,
    input  logic                 flush_req,
    output logic                 busy,
    output logic [WORD_SIZE-1:0] lookup_count,
    output logic [WORD_SIZE-1:0] mispredict_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = WORD_SIZE - IDX;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX-1:0]         clr_idx_q, clr_idx_d;
    logic [HIST_BITS-1:0]   ghr_q, ghr_d;
    logic [WORD_SIZE-1:0]   lookup_count_q, lookup_count_d;
    logic [WORD_SIZE-1:0]   mispredict_count_q, mispredict_count_d;

    logic [ENTRIES-1:0]     valid_q;
    logic [1:0]             pht_q    [ENTRIES];
    logic [TAG_W-1:0]       tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0]   target_q [ENTRIES];
    logic                   is_cond_q[ENTRIES];

    logic                   ghr_clear;
    logic                   upd_en;
    logic [IDX-1:0]         upd_idx;
    logic [IDX-1:0]         upd_pidx;
    logic [TAG_W-1:0]       upd_tag;
    logic [1:0]             pht_cur;
    logic [1:0]             pht_new;

    logic [IDX-1:0]         lk_idx;
    logic [IDX-1:0]         lk_pidx;
    logic [TAG_W-1:0]       lk_tag;
    logic [WORD_SIZE-1:0]   fall_through;

    // gshare folds the global history into the low PC bits; bimodal ignores it
    function automatic logic [IDX-1:0] pht_index(input logic [WORD_SIZE-1:0] pc,
                                                 input logic [HIST_BITS-1:0] hist);
        logic [IDX-1:0] base;
        base = pc[IDX-1:0];
        if (MODE == 1) begin
            return base ^ IDX'(hist);
        end
        return base;
    endfunction

    assign busy = (state_q == S_CLEAR);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ghr_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    state_d   = S_CLEAR;
                    clr_idx_d = '0;
                end
            end
            S_CLEAR: begin
                if (flush_req) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == IDX'(ENTRIES - 1)) begin
                    state_d   = S_IDLE;
                    clr_idx_d = '0;
                    ghr_clear = 1'b1;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                clr_idx_d = '0;
            end
        endcase
    end

    always_comb begin
        upd_en   = upd_valid && !busy;
        upd_idx  = upd_pc[IDX-1:0];
        upd_tag  = upd_pc[WORD_SIZE-1:IDX];
        upd_pidx = pht_index(upd_pc, ghr_q);
        pht_cur  = pht_q[upd_pidx];
        pht_new  = pht_cur;
        if (upd_taken && (pht_cur != 2'b11)) begin
            pht_new = pht_cur + 2'd1;
        end else if (!upd_taken && (pht_cur != 2'b00)) begin
            pht_new = pht_cur - 2'd1;
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (ghr_clear) begin
            ghr_d = '0;
        end else if (upd_en && upd_is_cond) begin
            ghr_d = (ghr_q << 1) | HIST_BITS'(upd_taken);
        end
    end

    always_comb begin
        lookup_count_d     = lookup_count_q;
        mispredict_count_d = mispredict_count_q;
        if (if_valid && !busy && (lookup_count_q != '1)) begin
            lookup_count_d = lookup_count_q + 1'b1;
        end
        if (upd_en && upd_mispredict && (mispredict_count_q != '1)) begin
            mispredict_count_d = mispredict_count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset_N) begin
        if (Reset_N) begin
            state_q            <= S_IDLE;
            clr_idx_q          <= '0;
            ghr_q              <= '0;
            lookup_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            state_q            <= state_d;
            clr_idx_q          <= clr_idx_d;
            ghr_q              <= ghr_d;
            lookup_count_q     <= lookup_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Clearing and training never collide: updates are dropped while busy
    always_ff @(posedge Clk or posedge Reset_N) begin
        if (Reset_N) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else if (busy) begin
            valid_q[clr_idx_q] <= 1'b0;
            pht_q[clr_idx_q]   <= 2'b01;
        end else if (upd_valid) begin
            if (upd_is_cond) begin
                pht_q[upd_pidx] <= pht_new;
            end
            if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
            end
        end
    end

    // Entry payload is qualified by valid_q, so it needs no reset
    always_ff @(posedge Clk) begin
        if (upd_en && upd_taken) begin
            tag_q[upd_idx]     <= upd_tag;
            target_q[upd_idx]  <= upd_target;
            is_cond_q[upd_idx] <= upd_is_cond;
        end
    end

    always_comb begin
        lk_idx       = if_pc[IDX-1:0];
        lk_tag       = if_pc[WORD_SIZE-1:IDX];
        lk_pidx      = pht_index(if_pc, ghr_q);
        fall_through = if_pc + WORD_SIZE'(1);
        pred_hit     = !busy && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken   = pred_hit && (!is_cond_q[lk_idx] || pht_q[lk_pidx][1]);
        pred_target  = pred_taken ? target_q[lk_idx] : fall_through;
    end

    assign lookup_count     = lookup_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor: a 16-bit bimodal
// instance and an 8-bit gshare instance driven from the same stimulus.
module tb_branch_predictor;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [15:0] tgt;
    } exp_t;

    typedef struct packed {
        logic        lv;
        logic [15:0] lpc;
        logic        uv;
        logic [15:0] upc;
        logic        uc;
        logic        ut;
        logic [15:0] utgt;
        logic        um;
        logic        eh;
        logic        et;
        logic [15:0] etgt;
    } step_t;

    logic        Clk;
    logic        Reset_N;
    logic        if_valid;
    logic [15:0] if_pc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_is_cond;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_mispredict;
    logic        flush_req;

    logic        pred_hit, pred_taken, busy;
    logic [15:0] pred_target, lookup_count, mispredict_count;
    logic        g_hit, g_taken, g_busy;
    logic [7:0]  g_target, g_lcount, g_mcount;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    branch_predictor #(.WORD_SIZE(16), .ENTRIES(16), .HIST_BITS(4), .MODE(0)) u_bi (
        .Clk(Clk), .Reset_N(Reset_N),
        .if_valid(if_valid), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush_req(flush_req), .busy(busy),
        .lookup_count(lookup_count), .mispredict_count(mispredict_count)
    );

    branch_predictor #(.WORD_SIZE(8), .ENTRIES(16), .HIST_BITS(4), .MODE(1)) u_gs (
        .Clk(Clk), .Reset_N(Reset_N),
        .if_valid(if_valid), .if_pc(if_pc[7:0]),
        .pred_hit(g_hit), .pred_taken(g_taken), .pred_target(g_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc[7:0]), .upd_is_cond(upd_is_cond),
        .upd_taken(upd_taken), .upd_target(upd_target[7:0]), .upd_mispredict(upd_mispredict),
        .flush_req(flush_req), .busy(g_busy),
        .lookup_count(g_lcount), .mispredict_count(g_mcount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic step_t lk(input logic [15:0] pc, input logic h, input logic t,
                                 input logic [15:0] tgt);
        step_t s = '0;
        s.lv = 1'b1; s.lpc = pc; s.eh = h; s.et = t; s.etgt = tgt;
        return s;
    endfunction

    function automatic step_t up(input logic [15:0] pc, input logic c, input logic t,
                                 input logic [15:0] tgt, input logic m);
        step_t s = '0;
        s.uv = 1'b1; s.upc = pc; s.uc = c; s.ut = t; s.utgt = tgt; s.um = m;
        return s;
    endfunction

    task automatic drive_idle();
        if_valid = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_is_cond = 1'b0;
        upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0; flush_req = 1'b0;
    endtask

    task automatic drive_step(input step_t s);
        exp_t e;
        if_valid = s.lv; if_pc = s.lpc;
        upd_valid = s.uv; upd_pc = s.upc; upd_is_cond = s.uc; upd_taken = s.ut;
        upd_target = s.utgt; upd_mispredict = s.um;
        if (s.lv) begin
            e.hit = s.eh; e.taken = s.et; e.tgt = s.etgt;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        Reset_N = 1'b1;
        drive_idle();
        if_pc = 16'h0005;
        @(negedge Clk); #2;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 16'h0006}) begin
            errors++;
            $display("FAIL reset_pred: got %b %b %h, expected 0 0 0006", pred_hit, pred_taken, pred_target);
        end
        checks++;
        if ({busy, lookup_count, mispredict_count} !== {1'b0, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state: got busy=%b lc=%h mc=%h, expected 0 0000 0000", busy, lookup_count, mispredict_count);
        end
        @(negedge Clk);
        Reset_N = 1'b0;
        drive_step(lk(16'h0005, 1'b0, 1'b0, 16'h0006));
        #2;
        e = exp_q.pop_front();
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== e) begin
            errors++;
            $display("FAIL reset_lookup: got %b %b %h, expected %b %b %h", pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
        end
        @(negedge Clk);
        drive_idle();
        #2;
        checks++;
        if ({lookup_count, mispredict_count} !== {16'h0001, 16'h0000}) begin
            errors++;
            $display("FAIL reset_counts: got lc=%h mc=%h, expected 0001 0000", lookup_count, mispredict_count);
        end
        @(negedge Clk);
    endtask

    task automatic test_bimodal();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(up(16'h0012, 1'b1, 1'b1, 16'h0040, 1'b0));
        tbl.push_back(lk(16'h0012, 1'b1, 1'b1, 16'h0040));
        tbl.push_back(step_t'(lk(16'h0012, 1'b1, 1'b1, 16'h0040) | up(16'h0012, 1'b1, 1'b0, 16'h0000, 1'b1)));
        tbl.push_back(step_t'(lk(16'h0012, 1'b1, 1'b0, 16'h0013) | up(16'h0012, 1'b1, 1'b0, 16'h0000, 1'b0)));
        tbl.push_back(lk(16'h0012, 1'b1, 1'b0, 16'h0013));
        tbl.push_back(up(16'h0012, 1'b1, 1'b0, 16'h0000, 1'b0));
        tbl.push_back(lk(16'h0012, 1'b1, 1'b0, 16'h0013));
        for (int i = 0; i < tbl.size(); i++) begin
            drive_step(tbl[i]);
            #2;
            if (tbl[i].lv) begin
                e = exp_q.pop_front();
                checks++;
                if ({pred_hit, pred_taken, pred_target} !== e) begin
                    errors++;
                    $display("FAIL bimodal[%0d]: got %b %b %h, expected %b %b %h", i, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
                end
            end
            @(negedge Clk);
        end
        drive_idle();
        #2;
        checks++;
        if ({lookup_count, mispredict_count} !== {16'd6, 16'd1}) begin
            errors++;
            $display("FAIL bimodal_counts: got lc=%0d mc=%0d, expected 6 1", lookup_count, mispredict_count);
        end
        @(negedge Clk);
    endtask

    task automatic test_alias();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(lk(16'h0022, 1'b0, 1'b0, 16'h0023));
        tbl.push_back(up(16'h0022, 1'b1, 1'b1, 16'h0080, 1'b0));
        tbl.push_back(lk(16'h0012, 1'b0, 1'b0, 16'h0013));
        tbl.push_back(lk(16'h0022, 1'b1, 1'b0, 16'h0023));
        for (int k = 0; k < 4; k++) tbl.push_back(up(16'h0022, 1'b1, 1'b1, 16'h0080, 1'b0));
        tbl.push_back(up(16'h0022, 1'b1, 1'b0, 16'h0000, 1'b0));
        tbl.push_back(lk(16'h0022, 1'b1, 1'b1, 16'h0080));
        for (int k = 0; k < 3; k++) tbl.push_back(up(16'h0022, 1'b1, 1'b0, 16'h0000, 1'b0));
        for (int k = 0; k < 2; k++) tbl.push_back(up(16'h0022, 1'b1, 1'b1, 16'h0080, 1'b0));
        tbl.push_back(lk(16'h0022, 1'b1, 1'b1, 16'h0080));
        for (int i = 0; i < tbl.size(); i++) begin
            drive_step(tbl[i]);
            #2;
            if (tbl[i].lv) begin
                e = exp_q.pop_front();
                checks++;
                if ({pred_hit, pred_taken, pred_target} !== e) begin
                    errors++;
                    $display("FAIL alias[%0d]: got %b %b %h, expected %b %b %h", i, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
                end
            end
            @(negedge Clk);
        end
        drive_idle();
    endtask

    task automatic test_uncond();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(up(16'h0030, 1'b0, 1'b1, 16'h0100, 1'b0));
        tbl.push_back(lk(16'h0030, 1'b1, 1'b1, 16'h0100));
        tbl.push_back(up(16'h0040, 1'b1, 1'b1, 16'h0200, 1'b0));
        tbl.push_back(lk(16'h0030, 1'b0, 1'b0, 16'h0031));
        tbl.push_back(up(16'h0040, 1'b1, 1'b0, 16'h0000, 1'b0));
        tbl.push_back(lk(16'h0040, 1'b1, 1'b0, 16'h0041));
        for (int i = 0; i < tbl.size(); i++) begin
            drive_step(tbl[i]);
            #2;
            if (tbl[i].lv) begin
                e = exp_q.pop_front();
                checks++;
                if ({pred_hit, pred_taken, pred_target} !== e) begin
                    errors++;
                    $display("FAIL uncond[%0d]: got %b %b %h, expected %b %b %h", i, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
                end
            end
            @(negedge Clk);
        end
        drive_idle();
    endtask

    task automatic test_flush();
        step_t tbl[$];
        exp_t  e;
        drive_step(lk(16'h0022, 1'b1, 1'b1, 16'h0080));
        flush_req = 1'b1;
        #2;
        e = exp_q.pop_front();
        checks++;
        if ({busy, pred_hit, pred_taken, pred_target} !== {1'b0, e}) begin
            errors++;
            $display("FAIL flush_pre: got busy=%b %b %b %h, expected 0 %b %b %h", busy, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
        end
        @(negedge Clk);
        flush_req = 1'b0;
        for (int cyc = 0; cyc <= 16; cyc++) begin
            if (cyc == 4)
                drive_step(step_t'(lk(16'h0022, 1'b0, 1'b0, 16'h0023) | up(16'h0050, 1'b1, 1'b1, 16'h0060, 1'b1)));
            else
                drive_step(lk(16'h0022, 1'b0, 1'b0, 16'h0023));
            #2;
            checks++;
            if (busy !== (cyc < 16)) begin
                errors++;
                $display("FAIL flush_busy[%0d]: got %b, expected %b", cyc, busy, (cyc < 16));
            end
            e = exp_q.pop_front();
            checks++;
            if ({pred_hit, pred_taken, pred_target} !== e) begin
                errors++;
                $display("FAIL flush_lookup[%0d]: got %b %b %h, expected %b %b %h", cyc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
            end
            @(negedge Clk);
        end
        tbl.push_back(lk(16'h0050, 1'b0, 1'b0, 16'h0051));
        tbl.push_back(lk(16'h0040, 1'b0, 1'b0, 16'h0041));
        tbl.push_back(up(16'h0022, 1'b1, 1'b1, 16'h0080, 1'b0));
        tbl.push_back(up(16'h0022, 1'b1, 1'b0, 16'h0000, 1'b0));
        tbl.push_back(lk(16'h0022, 1'b1, 1'b0, 16'h0023));
        for (int i = 0; i < tbl.size(); i++) begin
            drive_step(tbl[i]);
            #2;
            if (tbl[i].lv) begin
                e = exp_q.pop_front();
                checks++;
                if ({pred_hit, pred_taken, pred_target} !== e) begin
                    errors++;
                    $display("FAIL flush_after[%0d]: got %b %b %h, expected %b %b %h", i, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
                end
            end
            @(negedge Clk);
        end
        drive_idle();
        #2;
        checks++;
        if ({lookup_count, mispredict_count} !== {16'd19, 16'd1}) begin
            errors++;
            $display("FAIL flush_counts: got lc=%0d mc=%0d, expected 19 1", lookup_count, mispredict_count);
        end
        @(negedge Clk);
    endtask

    task automatic test_flush_restart();
        flush_req = 1'b1;
        @(negedge Clk);
        flush_req = 1'b0;
        for (int cyc = 0; cyc <= 21; cyc++) begin
            flush_req = (cyc == 4);
            #2;
            checks++;
            if (busy !== (cyc < 21)) begin
                errors++;
                $display("FAIL restart_busy[%0d]: got %b, expected %b", cyc, busy, (cyc < 21));
            end
            @(negedge Clk);
        end
        flush_req = 1'b0;
    endtask

    task automatic test_flush_reset();
        flush_req = 1'b1;
        @(negedge Clk);
        flush_req = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #2;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL midreset_busy[%0d]: got %b, expected 1", cyc, busy);
            end
            @(negedge Clk);
        end
        #2;
        Reset_N = 1'b1;
        #1;
        checks++;
        if ({busy, g_busy, pred_hit, pred_target, lookup_count, mispredict_count} !== {3'b000, 16'h0001, 16'h0000, 16'h0000}) begin
            errors++;
            $display("FAIL midreset_state: got busy=%b gbusy=%b hit=%b tgt=%h lc=%h mc=%h, expected 0 0 0 0001 0000 0000",
                     busy, g_busy, pred_hit, pred_target, lookup_count, mispredict_count);
        end
        @(negedge Clk);
        Reset_N = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_gshare();
        step_t tbl[$];
        exp_t  e;
        tbl.push_back(up(16'h0009, 1'b1, 1'b1, 16'h0020, 1'b0));
        tbl.push_back(up(16'h0009, 1'b1, 1'b1, 16'h0020, 1'b0));
        tbl.push_back(up(16'h0009, 1'b1, 1'b0, 16'h0000, 1'b0));
        tbl.push_back(up(16'h0009, 1'b1, 1'b1, 16'h0020, 1'b0));
        tbl.push_back(up(16'h0003, 1'b1, 1'b1, 16'h0050, 1'b0));
        tbl.push_back(lk(16'h0003, 1'b1, 1'b1, 16'h0050));
        tbl.push_back(up(16'h0006, 1'b1, 1'b1, 16'h0070, 1'b0));
        tbl.push_back(up(16'h0006, 1'b1, 1'b1, 16'h0070, 1'b0));
        tbl.push_back(up(16'h0006, 1'b1, 1'b0, 16'h0000, 1'b0));
        tbl.push_back(up(16'h0006, 1'b1, 1'b1, 16'h0070, 1'b0));
        tbl.push_back(lk(16'h0003, 1'b1, 1'b1, 16'h0050));
        for (int k = 0; k < 4; k++) tbl.push_back(up(16'h0006, 1'b1, 1'b0, 16'h0000, 1'b0));
        tbl.push_back(lk(16'h0003, 1'b1, 1'b0, 16'h0004));
        tbl.push_back(lk(16'h0009, 1'b1, 1'b0, 16'h000A));
        for (int i = 0; i < tbl.size(); i++) begin
            drive_step(tbl[i]);
            #2;
            if (tbl[i].lv) begin
                e = exp_q.pop_front();
                checks++;
                if ({g_hit, g_taken, g_target} !== {e.hit, e.taken, e.tgt[7:0]}) begin
                    errors++;
                    $display("FAIL gshare[%0d]: got %b %b %h, expected %b %b %h", i, g_hit, g_taken, g_target, e.hit, e.taken, e.tgt[7:0]);
                end
            end
            @(negedge Clk);
        end
        drive_idle();
    endtask

    task automatic test_counters();
        if_valid = 1'b1;
        upd_valid = 1'b1;
        upd_is_cond = 1'b0;
        upd_taken = 1'b0;
        upd_mispredict = 1'b1;
        repeat (10) @(negedge Clk);
        #2;
        checks++;
        if ({g_lcount, g_mcount} !== {8'd14, 8'd10}) begin
            errors++;
            $display("FAIL count_mid: got lc=%0d mc=%0d, expected 14 10", g_lcount, g_mcount);
        end
        repeat (290) @(negedge Clk);
        drive_idle();
        #2;
        checks++;
        if ({g_lcount, g_mcount} !== {8'd255, 8'd255}) begin
            errors++;
            $display("FAIL count_sat: got lc=%0d mc=%0d, expected 255 255", g_lcount, g_mcount);
        end
        checks++;
        if ({lookup_count, mispredict_count} !== {16'd304, 16'd300}) begin
            errors++;
            $display("FAIL count_wide: got lc=%0d mc=%0d, expected 304 300", lookup_count, mispredict_count);
        end
        @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_bimodal();
        test_alias();
        test_uncond();
        test_flush();
        test_flush_restart();
        test_flush_reset();
        test_gshare();
        test_counters();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer plus 2-bit pattern history table for the pipelined CPU. It replaces fixed fall-through fetch with a per-PC predicted next PC in IF. It is trained by resolved branches and jumps from EX, and offers bimodal or gshare indexing, a multi-cycle table flush, and saturating statistics counters.

## Interface
- WORD_SIZE, 16, PC/target width
- ENTRIES, 16, BTB and PHT depth; power of two, ≥2; IDX = log2(ENTRIES)
- HIST_BITS, 4, global history length; 1 ≤ HIST_BITS ≤ IDX
- MODE, 0, 0 = bimodal (PHT index = pc[IDX-1:0]), 1 = gshare (PHT index = pc[IDX-1:0] XOR zero-extended GHR)
- Clk  in  1  clock, all state on rising edge
- Reset_N  in  1  reset, asynchronous, active-high (1 = reset)
- if_valid  in  1  lookup request this cycle
- if_pc  in  WORD_SIZE  fetch PC
- pred_hit  out  1  BTB tag match, valid entry, not busy
- pred_taken  out  1  predicted taken
- pred_target  out  WORD_SIZE  predicted next PC
- upd_valid  in  1  resolved control instruction from EX
- upd_pc  in  WORD_SIZE  its PC
- upd_is_cond  in  1  1 = conditional branch, 0 = JMP/JAL
- upd_taken  in  1  actual outcome
- upd_target  in  WORD_SIZE  actual taken target
- upd_mispredict  in  1  EX-detected misprediction
- flush_req  in  1  start table clear
- busy  out  1  clear in progress
- lookup_count  out  WORD_SIZE  accepted lookups, saturating
- mispredict_count  out  WORD_SIZE  mispredicts, saturating

## Operation
- BTB entry: valid, tag = pc[WORD_SIZE-1:IDX], target, is_cond; indexed by pc[IDX-1:0]. PHT: ENTRIES 2-bit counters. GHR: HIST_BITS shift register, newest outcome in bit 0.
- Lookup is combinational. Hit requires valid and a tag match. pred_taken = hit && (!is_cond || PHT[pidx][1]). pred_target = BTB target if pred_taken, else if_pc+1 (mod 2^WORD_SIZE).
- Update when upd_valid && !busy:
  - If upd_is_cond, PHT[pidx(upd_pc)] saturating ±1 by upd_taken (3 max, 0 min) and GHR <= {GHR[HIST_BITS-2:0], upd_taken}.
  - If upd_taken, write the BTB entry (valid=1, tag, target, is_cond), overwriting any alias.
  - A not-taken update never writes or clears the BTB.
- pidx for an update uses the GHR value before that update's shift.
- Updates during busy are dropped, including their effect on counters and GHR.
- Flush FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on flush_req. A clear index counter starts at 0.
  - Each CLEAR cycle sets valid[idx]=0 and PHT[idx]=2'b01.
  - After idx = ENTRIES-1, go to IDLE and set GHR=0.
  - flush_req during CLEAR restarts the index at 0.
- While busy: pred_hit=0, pred_taken=0, pred_target=if_pc+1.
- lookup_count increments on if_valid && !busy. mispredict_count increments on upd_valid && upd_mispredict && !busy. Both hold at all-ones. Flush does not clear them.

## Timing
- Reset (async): all BTB valid=0, PHT=2'b01, GHR=0, FSM IDLE, busy=0, both counts 0. Outputs are then pred_hit=0, pred_taken=0, pred_target=if_pc+1.
- Lookup latency 0 cycles (same-cycle combinational).
- An update at edge N is visible to lookups from cycle N+1. A same-cycle lookup of the same entry sees the old contents (no bypass).
- flush_req sampled at edge N: busy=1 from N+1 through N+ENTRIES; busy=0 and tables usable at N+ENTRIES+1.
- Reset asserted mid-CLEAR: busy drops to 0 immediately (asynchronous) and all state takes reset values.

## Test plan
- Reset, then lookup if_pc=0x0005 → pred_hit=0, pred_taken=0, pred_target=0x0006; lookup_count=1 after the edge; mispredict_count=0.
- Bimodal: update pc=0x0012, cond, taken, target 0x0040 → next-cycle lookup 0x0012 gives hit=1, taken=1, target 0x0040. Then 2 not-taken updates → hit=1, taken=0, target 0x0013.
- Alias: after the previous case, lookup 0x0022 (same index 2, different tag) → hit=0, target 0x0023. A taken update at 0x0022→0x0080 evicts it, and 0x0012 then misses.
- Unconditional: update pc=0x0030, is_cond=0, taken, target 0x0100 → lookup taken=1, target 0x0100; PHT and GHR unchanged.
- Gshare (MODE=1, HIST_BITS=4): cond outcomes T,T,N,T → GHR=4'b1101. Update pc=0x0003 taken → PHT[0x3^0xD=0xE] goes 01→10; PHT[3] stays 01.
- Flush: with entries trained, pulse flush_req → busy=1 for exactly 16 cycles; lookups not-taken; an update in cycle 5 is dropped; all lookups miss afterwards. Repeat with Reset_N=1 at cycle 8 → busy=0 immediately.
